seq_voice_engine: RTL and testbench

//  Parametrised multi-track drum voice engine for the beat sequencer. Each step strobe

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_voice.sv | 48 ++++
 rtl/seq_voice_engine.sv | 91 +++++++++
 tb/tb_seq_voice_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: LFSR constants and the output saturation helper shared by the voice engine.
package seq_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 counted from 1, i.e. bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int ow);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/seq_voice.sv
// seq_voice: one drum voice holding trigger load, tone/noise polarity and a decaying envelope.
module seq_voice
  import seq_pkg::*;
#(
  parameter int EW = 8,
  parameter int PW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 poweron,
  input  logic                 trig,
  input  logic [EW-1:0]        load_env,
  input  logic                 tick,
  input  logic                 dec,
  input  logic                 noise,
  input  logic                 noise_bit,
  input  logic [PW-1:0]        period,
  output logic signed [EW:0]   value,
  output logic                 active
);
  typedef struct packed {
    logic [EW-1:0] env;
    logic [PW-1:0] phase;
    logic          polarity;
  } voice_t;
  voice_t v, v_nx;
  logic [PW-1:0] last;
  logic          flip;
  // A zero period behaves like one: polarity toggles on every sample.
  always_comb begin
    last = (period == '0) ? '0 : period - 1'b1;
    flip = v.phase == last;
    v_nx = v;
    if (!poweron)
      v_nx.env = '0;
    else if (trig)
      v_nx = voice_t'{env: load_env, phase: '0, polarity: 1'b1};
    else if (tick) begin
      v_nx.env = (dec && v.env != '0) ? v.env - 1'b1 : v.env;
      v_nx.phase = noise ? v.phase : (flip ? '0 : v.phase + 1'b1);
      v_nx.polarity = noise ? noise_bit : (flip ? ~v.polarity : v.polarity);
    end
  end
  always_ff @(posedge clk)
    v <= !rst_n ? voice_t'{env: '0, phase: '0, polarity: 1'b1} : v_nx;
  assign value = v.polarity ? $signed({1'b0, v.env}) : -$signed({1'b0, v.env});
  assign active = v.env != '0;
endmodule

// File: rtl/seq_voice_engine.sv
// seq_voice_engine: multi-track drum voice engine with trigger decode, shared decay prescaler and saturating mixer.
// Define SEQ_ACCENT_EN to add the per-step accent input (unaccented hits load half envelope).
module seq_voice_engine
  import seq_pkg::*;
#(
  parameter int TRACKS    = 7,
  parameter int STEPS     = 16,
  parameter int EW        = 8,
  parameter int PW        = 8,
  parameter int OW        = 16,
  parameter int DECAY_DIV = 4
) (
  input  logic                       MCLK,
  input  logic                       rst_n,
  input  logic                       poweron,
  input  logic                       step_tick,
  input  logic [$clog2(STEPS)-1:0]   step_idx,
  input  logic [TRACKS*STEPS-1:0]    pattern,
  input  logic [TRACKS-1:0]          track_mute,
  input  logic [TRACKS-1:0]          noise_sel,
  input  logic [TRACKS*PW-1:0]       tone_period,
`ifdef SEQ_ACCENT_EN
  input  logic [STEPS-1:0]           accent,
`endif
  input  logic                       sample_tick,
  output logic signed [OW-1:0]       audio_out,
  output logic                       sample_valid,
  output logic [TRACKS-1:0]          active
);
  localparam int MW = EW + 1 + $clog2(TRACKS);
  localparam int PRW = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
  localparam logic [EW-1:0] ENV_MAX = '1;
  logic [PRW-1:0]        presc;
  logic [15:0]           lfsr, lfsr_nx;
  logic                  tick_q, wrap, go;
  logic [EW-1:0]         load_env;
  logic [TRACKS-1:0]     trig;
  logic signed [EW:0]    vals [TRACKS];
  logic signed [MW-1:0]  sum;
  assign go = step_tick && poweron && 32'(step_idx) < STEPS;
  assign wrap = sample_tick && presc == PRW'(DECAY_DIV - 1);
  assign lfsr_nx = lfsr_step(lfsr);
`ifdef SEQ_ACCENT_EN
  assign load_env = accent[step_idx] ? ENV_MAX : ENV_MAX >> 1;
`else
  assign load_env = ENV_MAX;
`endif
  for (genvar t = 0; t < TRACKS; t++) begin : g_trk
    logic [STEPS-1:0] row;
    assign row = pattern[t*STEPS +: STEPS];
    assign trig[t] = go && row[step_idx] && !track_mute[t];
    seq_voice #(.EW(EW), .PW(PW)) u_voice (
      .clk       (MCLK),
      .rst_n     (rst_n),
      .poweron   (poweron),
      .trig      (trig[t]),
      .load_env  (load_env),
      .tick      (sample_tick),
      .dec       (wrap),
      .noise     (noise_sel[t]),
      .noise_bit (lfsr_nx[0]),
      .period    (tone_period[t*PW +: PW]),
      .value     (vals[t]),
      .active    (active[t])
    );
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < TRACKS; i++)
      sum = sum + MW'(vals[i]);
  end
  // Stage 2 mixes the voice state produced by the previous sample_tick.
  always_ff @(posedge MCLK) begin
    if (!rst_n) begin
      presc <= '0;
      lfsr <= LFSR_SEED;
      tick_q <= 1'b0;
      sample_valid <= 1'b0;
      audio_out <= '0;
    end else begin
      if (sample_tick) begin
        presc <= wrap ? '0 : presc + 1'b1;
        lfsr <= lfsr_nx;
      end
      tick_q <= sample_tick;
      sample_valid <= tick_q;
      if (tick_q)
        audio_out <= poweron ? OW'(sat(32'(sum), OW)) : '0;
    end
  end
endmodule

// File: tb/tb_seq_voice_engine.sv
// tb_seq_voice_engine: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_seq_voice_engine;
  localparam int T = 7;
  localparam int S = 16;
  logic MCLK = 1'b0;
  logic rst_n, poweron, step_tick, sample_tick;
  logic [3:0] step_idx;
  logic [T*S-1:0] pattern;
  logic [T*12-1:0] pattern2;
  logic [T-1:0] track_mute, noise_sel, active, active2, exp_act;
  logic [T*8-1:0] tone_period;
  logic signed [15:0] audio_out;
  logic signed [9:0] audio2;
  logic sample_valid, valid2;
  int n_checks = 0;
  int n_fail = 0;
  int m_ticks, m_out;
  logic [15:0] m_lfsr;
  bit m_live [T];
  int m_tt [T];
  int m_tw [T];
  bit m_pend, m_valid;

  typedef struct {
    bit rst_n, pwr, st;
    logic [3:0] idx;
    bit tick, valid;
    int audio;
    bit act;
  } vec_t;
  vec_t tbl [16];

  always #5 MCLK = ~MCLK;

  seq_voice_engine dut (
    .MCLK(MCLK), .rst_n(rst_n), .poweron(poweron), .step_tick(step_tick), .step_idx(step_idx),
    .pattern(pattern), .track_mute(track_mute), .noise_sel(noise_sel), .tone_period(tone_period),
    .sample_tick(sample_tick), .audio_out(audio_out), .sample_valid(sample_valid), .active(active)
  );
  seq_voice_engine #(.STEPS(12), .OW(10)) dut2 (
    .MCLK(MCLK), .rst_n(rst_n), .poweron(poweron), .step_tick(step_tick), .step_idx(step_idx),
    .pattern(pattern2), .track_mute(track_mute), .noise_sel(noise_sel), .tone_period(tone_period),
    .sample_tick(sample_tick), .audio_out(audio2), .sample_valid(valid2), .active(active2)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Envelope: load value minus prescaler wraps seen since the trigger.
  function automatic int m_env(int t);
    int e;
    e = m_live[t] ? 255 - (m_ticks / 4 - m_tw[t]) : 0;
    return e > 0 ? e : 0;
  endfunction

  // Tone polarity flips after every 'period' samples since the trigger.
  function automatic int m_val(int t);
    int k, per;
    bit pol;
    k = m_ticks - m_tt[t];
    per = tone_period[t*8 +: 8] == 8'd0 ? 1 : int'(tone_period[t*8 +: 8]);
    pol = noise_sel[t] ? (k > 0 ? m_lfsr[0] : 1'b1) : ((k / per) % 2 == 0);
    return pol ? m_env(t) : -m_env(t);
  endfunction

  task automatic model_edge();
    int s;
    if (!rst_n) begin
      m_ticks = 0;
      m_lfsr = 16'hACE1;
      m_pend = 0;
      m_valid = 0;
      m_out = 0;
      for (int t = 0; t < T; t++) m_live[t] = 0;
    end else begin
      m_valid = m_pend;
      if (m_pend) begin
        s = 0;
        for (int t = 0; t < T; t++) s += m_val(t);
        m_out = !poweron ? 0 : (s > 32767 ? 32767 : (s < -32768 ? -32768 : s));
      end
      if (sample_tick) begin
        m_ticks++;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
      for (int t = 0; t < T; t++)
        if (!poweron) m_live[t] = 0;
        else if (step_tick && pattern[t*S + int'(step_idx)] && !track_mute[t]) begin
          m_live[t] = 1;
          m_tt[t] = m_ticks;
          m_tw[t] = m_ticks / 4;
        end
      m_pend = sample_tick;
    end
  endtask

  task automatic cyc();
    @(posedge MCLK);
    model_edge();
    #1;
  endtask

  task automatic tick_pair();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_tick = 1'b0;
    sample_tick = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic trigger(input logic [3:0] i);
    step_tick = 1'b1;
    step_idx = i;
    cyc();
    step_tick = 1'b0;
  endtask

  initial begin
    int fall;
    logic seen;
    rst_n = 1'b0;
    poweron = 1'b1;
    step_tick = 1'b0;
    step_idx = '0;
    sample_tick = 1'b0;
    pattern = '0;
    pattern2 = '0;
    track_mute = '0;
    noise_sel = '0;
    tone_period = {T{8'd2}};
    // Track 0, tone period 2, hit on step 3: fields rst_n,pwr,st,idx,tick | valid,audio,active[0]
    pattern[3] = 1'b1;
    tbl[0]  = '{0, 0, 0, 4'd0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 4'd3, 0, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 4'd0, 1, 0, 0, 1};
    tbl[3]  = '{1, 1, 0, 4'd0, 0, 1, 255, 1};
    tbl[4]  = '{1, 1, 0, 4'd0, 1, 0, 255, 1};
    tbl[5]  = '{1, 1, 0, 4'd0, 0, 1, -255, 1};
    tbl[6]  = '{1, 1, 0, 4'd0, 1, 0, -255, 1};
    tbl[7]  = '{1, 1, 0, 4'd0, 1, 1, -255, 1};
    tbl[8]  = '{1, 1, 0, 4'd0, 0, 1, 254, 1};
    tbl[9]  = '{1, 1, 1, 4'd5, 0, 0, 254, 1};
    tbl[10] = '{1, 0, 0, 4'd0, 0, 0, 254, 0};
    tbl[11] = '{1, 0, 0, 4'd0, 1, 0, 254, 0};
    tbl[12] = '{1, 0, 0, 4'd0, 0, 1, 0, 0};
    tbl[13] = '{1, 1, 1, 4'd3, 1, 0, 0, 1};
    tbl[14] = '{1, 1, 0, 4'd0, 0, 1, 255, 1};
    tbl[15] = '{0, 1, 0, 4'd0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n;
      poweron = tbl[i].pwr;
      step_tick = tbl[i].st;
      step_idx = tbl[i].idx;
      sample_tick = tbl[i].tick;
      cyc();
      chk($sformatf("vec%0d_valid", i), sample_valid, tbl[i].valid);
      chk($sformatf("vec%0d_audio", i), audio_out, tbl[i].audio);
      chk($sformatf("vec%0d_active0", i), active[0], tbl[i].act);
    end
    // Full decay from one hit with no further steps.
    poweron = 1'b1;
    do_reset();
    trigger(4'd3);
    fall = 0;
    for (int i = 1; i <= 1100 && fall == 0; i++) begin
      tick_pair();
      if (!active[0]) fall = i;
    end
    chk("decay_fall_window", (fall >= 1017 && fall <= 1020), 1);
    tick_pair();
    chk("decay_silent_audio", audio_out, 0);
    // Muted track never sounds; an unmuted neighbour does.
    do_reset();
    pattern = '0;
    pattern[2*S +: S] = '1;
    pattern[3*S +: S] = '1;
    track_mute = 7'b0000100;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      trigger(4'(i));
      seen |= active[2];
    end
    chk("mute_track2_active", seen, 0);
    chk("unmuted_track3_active", active[3], 1);
    track_mute = '0;
    // Retrigger mid-decay on a sample tick that also wraps the prescaler.
    do_reset();
    pattern = '0;
    pattern[1*S + 7] = 1'b1;
    tone_period = {T{8'd3}};
    trigger(4'd7);
    repeat (623) tick_pair();
    chk("mid_decay_audio", audio_out, -100);
    step_tick = 1'b1;
    step_idx = 4'd7;
    sample_tick = 1'b1;
    cyc();
    step_tick = 1'b0;
    sample_tick = 1'b0;
    cyc();
    chk("retrig_audio", audio_out, 255);
    chk("retrig_active1", active[1], 1);
    tick_pair();
    chk("retrig_no_decrement", audio_out, 255);
    // Seven full-scale tones: raw sum on the wide build, clamped on the OW=10 build.
    do_reset();
    pattern = '1;
    pattern2 = '1;
    tone_period = {T{8'd255}};
    trigger(4'd0);
    tick_pair();
    chk("sum_wide", audio_out, 1785);
    chk("clamp_hi", audio2, 511);
    repeat (253) tick_pair();
    chk("clamp_hi_late", audio2, 511);
    tick_pair();
    chk("sum_wide_neg", audio_out, -1344);
    chk("clamp_lo", audio2, -512);
    // Steps beyond the pattern length on the 12-step build never trigger.
    do_reset();
    trigger(4'd13);
    trigger(4'd15);
    chk("idx_out_of_range", active2, 0);
    trigger(4'd11);
    chk("idx_last_step", active2, 7'h7f);
    // Randomized playback against the model.
    noise_sel = 7'($urandom);
    for (int t = 0; t < T; t++) tone_period[t*8 +: 8] = 8'($urandom_range(0, 4));
    track_mute = 7'($urandom) & 7'($urandom);
    for (int b = 0; b < T*S; b++) pattern[b] = $urandom_range(0, 3) == 0;
    poweron = 1'b1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = $urandom_range(0, 1499) != 0;
      poweron = poweron ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 9) == 0);
      step_tick = $urandom_range(0, 29) == 0;
      step_idx = 4'($urandom);
      sample_tick = $urandom_range(0, 2) == 0;
      cyc();
      for (int t = 0; t < T; t++) exp_act[t] = m_env(t) != 0;
      chk("rand_valid", sample_valid, m_valid);
      chk("rand_audio", audio_out, m_out);
      chk("rand_active", active, exp_act);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
